kamus_regfile: RTL and testbench
================================

# kamus_regfile

Integer register file and write-pending scoreboard for the kamus core. It receives the WB stage's write port, serves the two ID-stage read ports with same-cycle write bypass, and tracks in-flight writers per register. From those counters it produces an operand-hazard stall and an issue back-pressure signal. Reads are combinational; writes and scoreboard updates take effect on the rising clock edge.

## Interface
- XLEN, 32, data width of every register
- NUM_REGS, 32, architectural register count (address width = $clog2(NUM_REGS))
- PEND_W, 2, width of each per-register pending counter (max value 2**PEND_W-1)

- clk_i  in  1  core clock
- rst_ni  in  1  reset; one clock, asynchronous assert, active-low
- rs1_addr_i  in  5  ID read address, operand 1
- rs2_addr_i  in  5  ID read address, operand 2
- rs1_used_i  in  1  operand 1 is consumed by the decoding instruction
- rs2_used_i  in  1  operand 2 is consumed by the decoding instruction
- rs1_data_o  out  XLEN  operand 1 data
- rs2_data_o  out  XLEN  operand 2 data
- regfile_wr_en_i  in  1  WB write enable
- rd_addr_i  in  5  WB destination
- wb_data_i  in  XLEN  WB write data
- issue_valid_i  in  1  ID issues an instruction this cycle
- issue_wr_en_i  in  1  the issued instruction writes a register
- issue_rd_addr_i  in  5  destination of the issued instruction
- flush_i  in  1  pipeline flush; clears all pending counters
- hazard_o  out  1  a used source operand has an unresolved pending writer
- issue_ready_o  out  1  the pending counter of issue_rd_addr_i can accept another writer

## Operation
- Register x0:
  - Reads always return 0.
  - Writes to x0 are ignored.
  - Issues to x0 never change any counter.
- Read path (combinational). For each port:
  - If regfile_wr_en_i is high and rd_addr_i equals the port address (non-zero), the port returns wb_data_i.
  - Otherwise the port returns the stored array value.
- Write: on the clock edge with regfile_wr_en_i high and rd_addr_i != 0, array[rd_addr_i] <= wb_data_i.
- Pending counters: one PEND_W-bit counter per register 1..NUM_REGS-1.
  - inc: issue_valid_i & issue_wr_en_i & issue_ready_o & issue_rd_addr_i != 0
  - dec: regfile_wr_en_i & rd_addr_i != 0
  - inc and dec on the same register in the same cycle: counter is unchanged.
  - inc on a counter at max: blocked, because issue_ready_o is low.
  - dec on a counter at 0: counter stays 0 (saturating; WB of a flushed instruction).
- Flush: flush_i has priority over inc and dec. All counters are set to 0 at the next edge. The array is not affected, and a WB write in the same cycle still commits.
- Hazard, per port:
  - hazard_x = used_x & addr_x != 0 & (cnt[addr_x] > 1 | (cnt[addr_x] == 1 & !(regfile_wr_en_i & rd_addr_i == addr_x)))
  - hazard_o = hazard_1 | hazard_2.
  - Rationale: a single pending writer that is completing this cycle is covered by the bypass.
- issue_ready_o = !(issue_wr_en_i & issue_rd_addr_i != 0 & cnt[issue_rd_addr_i] == max & !dec on that register). It is combinational and does not depend on issue_valid_i.

## Timing
- Reset:
  - All registers are 0 and all counters are 0.
  - Outputs: rs*_data_o = 0 when not bypassed, hazard_o = 0, issue_ready_o = 1.
- Read latency is 0 cycles. A write is visible through the bypass in the same cycle and from the array starting at the next cycle.
- A counter increment is visible to hazard_o in the cycle after the issue. An instruction issued in cycle N with rd = x5 makes a reader of x5 in cycle N+1 see hazard_o = 1.
- Reset asserted mid-operation clears the array and counters immediately (asynchronously). WB or issue activity in the same cycle is discarded.
- No handshake exists on the WB port: every asserted write is accepted.

## Structure
- Shared kamus_pkg holds:
  - REG_ADDR_W = 5
  - XLEN = 32
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0])
- Sub-module kamus_scoreboard holds the pending counters, inc/dec/flush logic, hazard_o and issue_ready_o. The kamus_regfile top holds the array and the bypass muxes.

## Test plan
- Reset, then read x0..x31 on both ports -> all 0; hazard_o = 0; issue_ready_o = 1.
- WB writes x7 = 0xDEADBEEF with rs1_addr = 7 in the same cycle -> rs1_data_o = 0xDEADBEEF that cycle and on every later cycle. WB writes x0 = 0x1 -> x0 still reads 0.
- Issue rd = x5 in cycle N; read rs2 = x5 with rs2_used = 1 in cycle N+1 -> hazard_o = 1 until the WB cycle of x5 = 0x55. In that cycle hazard_o = 0 and rs2_data_o = 0x55.
- Issue rd = x9 three times with no WB -> cnt = 3 and issue_ready_o = 0 for a fourth x9 issue. Then a WB to x9 together with a fourth issue -> the issue is accepted and cnt stays 3.
- Issue x3 and x4, then assert flush_i -> next cycle both counters are 0 and hazard_o = 0 on reads of x3 and x4. A later stale WB to x3 writes the array and leaves cnt = 0.
- Write x12 = 0xA5A5A5A5, then pulse rst_ni low between clock edges -> x12 reads 0 immediately and all counters are 0.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared kamus core types: register address width, data width and the address type.
package kamus_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/kamus_regfile_if.sv
// ID read ports, WB write port and issue/scoreboard signals of the kamus register file.
interface kamus_regfile_if
    import kamus_pkg::*;
#(
    parameter int DATA_W = kamus_pkg::XLEN
) ();
    reg_addr_t           rs1_addr_i;
    reg_addr_t           rs2_addr_i;
    logic                rs1_used_i;
    logic                rs2_used_i;
    logic [DATA_W-1:0]   rs1_data_o;
    logic [DATA_W-1:0]   rs2_data_o;
    logic                regfile_wr_en_i;
    reg_addr_t           rd_addr_i;
    logic [DATA_W-1:0]   wb_data_i;
    logic                issue_valid_i;
    logic                issue_wr_en_i;
    reg_addr_t           issue_rd_addr_i;
    logic                flush_i;
    logic                hazard_o;
    logic                issue_ready_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        output regfile_wr_en_i, rd_addr_i, wb_data_i,
        output issue_valid_i, issue_wr_en_i, issue_rd_addr_i, flush_i,
        input  rs1_data_o, rs2_data_o, hazard_o, issue_ready_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        input  regfile_wr_en_i, rd_addr_i, wb_data_i,
        input  issue_valid_i, issue_wr_en_i, issue_rd_addr_i, flush_i,
        output rs1_data_o, rs2_data_o, hazard_o, issue_ready_o
    );
endinterface

// File: rtl/kamus_scoreboard.sv
// Per-register pending-writer counters with operand hazard and issue back-pressure.
module kamus_scoreboard
    import kamus_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  logic      rs1_used,
    input  logic      rs2_used,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  logic      issue_valid,
    input  logic      issue_wr_en,
    input  reg_addr_t issue_rd_addr,
    input  logic      flush,
    output logic      hazard,
    output logic      issue_ready
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam reg_addr_t         X0      = '0;

    logic [PEND_W-1:0] cnt_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_d [NUM_REGS];
    logic              dec_any;
    logic              inc_any;

    // A lone pending writer retiring this cycle is covered by the read bypass.
    function automatic logic port_hazard(input logic used, input reg_addr_t addr,
                                         input logic [PEND_W-1:0] cnt, input logic wb_hit);
        return used && (addr != X0) &&
               ((cnt > 1) || ((cnt == 1) && !wb_hit));
    endfunction

    assign dec_any     = wr_en && (wr_addr != X0);
    assign issue_ready = !(issue_wr_en && (issue_rd_addr != X0) &&
                           (cnt_q[issue_rd_addr] == CNT_MAX) &&
                           !(dec_any && (wr_addr == issue_rd_addr)));
    assign inc_any     = issue_valid && issue_wr_en && issue_ready && (issue_rd_addr != X0);

    assign hazard = port_hazard(rs1_used, rs1_addr, cnt_q[rs1_addr],
                                wr_en && (wr_addr == rs1_addr)) ||
                    port_hazard(rs2_used, rs2_addr, cnt_q[rs2_addr],
                                wr_en && (wr_addr == rs2_addr));

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            logic inc;
            logic dec;
            inc = inc_any && (issue_rd_addr == reg_addr_t'(i));
            dec = dec_any && (wr_addr == reg_addr_t'(i));
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec && !inc && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/kamus_regfile.sv
// kamus integer register file: storage array, WB write port and same-cycle read bypass.
module kamus_regfile #(
    parameter int XLEN     = kamus_pkg::XLEN,
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    kamus_regfile_if.slave   bus
);
    import kamus_pkg::*;

    localparam reg_addr_t X0 = '0;

    logic [XLEN-1:0] mem_q [NUM_REGS];
    logic            wr_hit;

    assign wr_hit = bus.regfile_wr_en_i && (bus.rd_addr_i != X0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[bus.rd_addr_i] <= bus.wb_data_i;
        end
    end

    always_comb begin
        bus.rs1_data_o = '0;
        bus.rs2_data_o = '0;
        if (bus.rs1_addr_i != X0) begin
            bus.rs1_data_o = (wr_hit && (bus.rd_addr_i == bus.rs1_addr_i)) ?
                             bus.wb_data_i : mem_q[bus.rs1_addr_i];
        end
        if (bus.rs2_addr_i != X0) begin
            bus.rs2_data_o = (wr_hit && (bus.rd_addr_i == bus.rs2_addr_i)) ?
                             bus.wb_data_i : mem_q[bus.rs2_addr_i];
        end
    end

    kamus_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rs1_addr      (bus.rs1_addr_i),
        .rs2_addr      (bus.rs2_addr_i),
        .rs1_used      (bus.rs1_used_i),
        .rs2_used      (bus.rs2_used_i),
        .wr_en         (bus.regfile_wr_en_i),
        .wr_addr       (bus.rd_addr_i),
        .issue_valid   (bus.issue_valid_i),
        .issue_wr_en   (bus.issue_wr_en_i),
        .issue_rd_addr (bus.issue_rd_addr_i),
        .flush         (bus.flush_i),
        .hazard        (bus.hazard_o),
        .issue_ready   (bus.issue_ready_o)
    );
endmodule

// File: tb/tb_kamus_regfile.sv
// Bench for kamus_regfile: directed vector table, reset pulse sequence, random traffic vs a model.
module tb_kamus_regfile;
    import kamus_pkg::*;

    localparam int NR   = 32;
    localparam int CMAX = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    kamus_regfile_if bus ();

    kamus_regfile #(.XLEN(32), .NUM_REGS(NR), .PEND_W(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rs1, rs2, u1, u2, we, rd;
        logic [31:0] wd;
        int          iv, iw, ird, fl;
        logic [31:0] e1, e2;
        int          eh, er;
    } vec_t;

    vec_t        vecs[$];
    int unsigned m_mem[NR];
    int          m_cnt[NR];

    function automatic vec_t mk(input int rs1, input int rs2, input int u1, input int u2,
                                input int we, input int rd, input logic [31:0] wd,
                                input int iv, input int iw, input int ird, input int fl,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input int eh, input int er);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.we = we; v.rd = rd; v.wd = wd;
        v.iv = iv; v.iw = iw; v.ird = ird; v.fl = fl;
        v.e1 = e1; v.e2 = e2; v.eh = eh; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int rs1, input int rs2, input int u1, input int u2,
                         input int we, input int rd, input logic [31:0] wd,
                         input int iv, input int iw, input int ird, input int fl);
        bus.rs1_addr_i      = reg_addr_t'(rs1);
        bus.rs2_addr_i      = reg_addr_t'(rs2);
        bus.rs1_used_i      = (u1 != 0);
        bus.rs2_used_i      = (u2 != 0);
        bus.regfile_wr_en_i = (we != 0);
        bus.rd_addr_i       = reg_addr_t'(rd);
        bus.wb_data_i       = wd;
        bus.issue_valid_i   = (iv != 0);
        bus.issue_wr_en_i   = (iw != 0);
        bus.issue_rd_addr_i = reg_addr_t'(ird);
        bus.flush_i         = (fl != 0);
    endtask

    // Reference model: expected outputs from the current stimulus and model state.
    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (bus.regfile_wr_en_i && int'(bus.rd_addr_i) == a) return bus.wb_data_i;
        return m_mem[a];
    endfunction

    function automatic logic m_port_haz(input logic used, input int a);
        logic retiring;
        retiring = bus.regfile_wr_en_i && int'(bus.rd_addr_i) == a;
        return used && a != 0 && (m_cnt[a] >= 2 || (m_cnt[a] == 1 && !retiring));
    endfunction

    function automatic logic m_ready();
        int d;
        d = int'(bus.issue_rd_addr_i);
        return !(bus.issue_wr_en_i && d != 0 && m_cnt[d] == CMAX &&
                 !(bus.regfile_wr_en_i && int'(bus.rd_addr_i) == d));
    endfunction

    task automatic m_clock(input logic rdy);
        int d, w;
        d = int'(bus.issue_rd_addr_i);
        w = int'(bus.rd_addr_i);
        if (bus.regfile_wr_en_i && w != 0) m_mem[w] = bus.wb_data_i;
        if (bus.flush_i) begin
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        end else begin
            if (bus.issue_valid_i && bus.issue_wr_en_i && rdy && d != 0) m_cnt[d] = m_cnt[d] + 1;
            if (bus.regfile_wr_en_i && w != 0 && m_cnt[w] > 0) m_cnt[w] = m_cnt[w] - 1;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // all registers read zero after reset
        for (int i = 0; i < NR; i++) begin
            drive(i, NR - 1 - i, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0);
            #1;
            chk($sformatf("rst_rs1_x%0d", i), bus.rs1_data_o, 32'h0);
            chk($sformatf("rst_rs2_x%0d", NR - 1 - i), bus.rs2_data_o, 32'h0);
        end
        chk("rst_hazard", {31'h0, bus.hazard_o}, 32'h0);
        chk("rst_ready", {31'h0, bus.issue_ready_o}, 32'h1);
        @(negedge clk);

        //               rs1 rs2 u1 u2 we rd wd            iv iw ird fl  e1            e2            eh er
        vecs.push_back(mk(0, 31, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(7, 0,  0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        0, 1));
        vecs.push_back(mk(7, 7,  1, 1, 1, 0, 32'h1,        0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 7,  0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 1));
        vecs.push_back(mk(0, 5,  0, 1, 0, 0, 32'h0,        1, 1, 5, 0, 32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(0, 5,  0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 5,  0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 5,  0, 1, 1, 5, 32'h55,       0, 0, 0, 0, 32'h0,        32'h55,       0, 1));
        vecs.push_back(mk(0, 5,  0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h55,       0, 1));
        vecs.push_back(mk(9, 0,  1, 0, 0, 0, 32'h0,        1, 1, 9, 0, 32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(9, 0,  1, 0, 0, 0, 32'h0,        1, 1, 9, 0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(9, 0,  1, 0, 0, 0, 32'h0,        1, 1, 9, 0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(9, 0,  0, 0, 0, 0, 32'h0,        1, 1, 9, 0, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(9, 0,  1, 0, 0, 0, 32'h0,        0, 1, 9, 0, 32'h0,        32'h0,        1, 0));
        vecs.push_back(mk(9, 0,  1, 0, 1, 9, 32'h99,       1, 1, 9, 0, 32'h99,       32'h0,        1, 1));
        vecs.push_back(mk(9, 0,  0, 0, 0, 0, 32'h0,        0, 1, 9, 0, 32'h99,       32'h0,        0, 0));
        vecs.push_back(mk(3, 0,  1, 0, 0, 0, 32'h0,        1, 1, 3, 0, 32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(3, 0,  1, 0, 0, 0, 32'h0,        1, 1, 4, 0, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(3, 4,  1, 1, 0, 0, 32'h0,        0, 0, 0, 1, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(3, 4,  1, 1, 0, 0, 32'h0,        0, 1, 9, 0, 32'h0,        32'h0,        0, 1));
        vecs.push_back(mk(3, 0,  1, 0, 1, 3, 32'h33,       0, 0, 0, 0, 32'h33,       32'h0,        0, 1));
        vecs.push_back(mk(3, 0,  1, 0, 0, 0, 32'h0,        1, 1, 3, 0, 32'h33,       32'h0,        0, 1));
        vecs.push_back(mk(3, 0,  1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h33,       32'h0,        1, 1));
        vecs.push_back(mk(12, 0, 1, 0, 1, 12, 32'hA5A5A5A5, 0, 0, 0, 1, 32'hA5A5A5A5, 32'h0,       0, 1));
        vecs.push_back(mk(12, 3, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'hA5A5A5A5, 32'h33,       0, 1));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rs1, vecs[k].rs2, vecs[k].u1, vecs[k].u2, vecs[k].we, vecs[k].rd,
                  vecs[k].wd, vecs[k].iv, vecs[k].iw, vecs[k].ird, vecs[k].fl);
            #2;
            chk($sformatf("vec%0d_rs1", k), bus.rs1_data_o, vecs[k].e1);
            chk($sformatf("vec%0d_rs2", k), bus.rs2_data_o, vecs[k].e2);
            chk($sformatf("vec%0d_hazard", k), {31'h0, bus.hazard_o}, 32'(vecs[k].eh));
            chk($sformatf("vec%0d_ready", k), {31'h0, bus.issue_ready_o}, 32'(vecs[k].er));
            @(negedge clk);
        end

        // asynchronous reset between edges, with WB/issue activity held during reset
        drive(12, 7, 1, 0, 0, 0, 32'h0, 1, 1, 12, 0);
        @(negedge clk);
        drive(12, 7, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        #2;
        chk("prerst_rs1", bus.rs1_data_o, 32'hA5A5A5A5);
        chk("prerst_hazard", {31'h0, bus.hazard_o}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstpulse_rs1", bus.rs1_data_o, 32'h0);
        chk("rstpulse_rs2", bus.rs2_data_o, 32'h0);
        chk("rstpulse_hazard", {31'h0, bus.hazard_o}, 32'h0);
        chk("rstpulse_ready", {31'h0, bus.issue_ready_o}, 32'h1);
        drive(12, 7, 1, 0, 1, 12, 32'hFFFFFFFF, 1, 1, 12, 0);
        @(posedge clk);
        #1 drive(12, 7, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("postrst_rs1", bus.rs1_data_o, 32'h0);
        chk("postrst_hazard", {31'h0, bus.hazard_o}, 32'h0);
        @(negedge clk);

        // random traffic against the model, narrow address range for collisions
        for (int i = 0; i < NR; i++) begin
            m_mem[i] = 0;
            m_cnt[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            logic rdy;
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0 ? 1 : 0,
                  $urandom_range(0, 7), $urandom_range(0, 15) == 0 ? 1 : 0);
            #2;
            rdy = m_ready();
            chk($sformatf("rnd%0d_rs1", c), bus.rs1_data_o, m_read(int'(bus.rs1_addr_i)));
            chk($sformatf("rnd%0d_rs2", c), bus.rs2_data_o, m_read(int'(bus.rs2_addr_i)));
            chk($sformatf("rnd%0d_hazard", c), {31'h0, bus.hazard_o},
                {31'h0, m_port_haz(bus.rs1_used_i, int'(bus.rs1_addr_i)) ||
                        m_port_haz(bus.rs2_used_i, int'(bus.rs2_addr_i))});
            chk($sformatf("rnd%0d_ready", c), {31'h0, bus.issue_ready_o}, {31'h0, rdy});
            @(posedge clk);
            m_clock(rdy);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
